// File: rtl/spike_driver_spi_mc.sv
// SPI-slave spike driver: 16-bit command frames fire single lines or masked groups of 8 lines.
// Optional status shift-out on lmiso is built when SDRV_STATUS_EN is defined.
module spike_driver_spi_mc #(
    parameter int SZPFIRED = 32,
    parameter int PULSEW   = 4,
    parameter int FRAMEW   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lsck,
    input  logic                lmosi,
    input  logic                lnss,
    output logic                lmiso,
    output logic [SZPFIRED-1:0] FOut
);

    localparam int              CW         = $clog2(FRAMEW + 1);
    localparam logic [CW-1:0]   FRAME_FULL = CW'(FRAMEW);
    localparam logic [7:0]      PW         = 8'(PULSEW);

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_FIRE = 2'b01,
        CMD_MASK = 2'b10,
        CMD_STAT = 2'b11
    } cmd_e;

    logic          sck_s1_q, sck_s2_q, sck_d1_q;
    logic          mosi_s1_q, mosi_s2_q;
    logic          nss_s1_q, nss_s2_q, nss_d1_q;
    logic          rise_q;
    logic [15:0]   shift_q, shift_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]    fired_cnt_q, fired_cnt_d;
    logic          err_q, err_d;
    logic [7:0]    cnt_q [SZPFIRED];

    logic                dec, abort, dec_err, err_clr, nss_rise;
    logic                idx_ok, grp_ok;
    cmd_e                cmd;
    logic [7:0]          add_cnt;
    logic [SZPFIRED-1:0] fire_vec;

    // Registered edge pulse puts decode on the 4th edge after lsck is first sampled high
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_d1_q  <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            nss_s1_q  <= 1'b1;
            nss_s2_q  <= 1'b1;
            nss_d1_q  <= 1'b1;
            rise_q    <= 1'b0;
        end else begin
            sck_s1_q  <= lsck;
            sck_s2_q  <= sck_s1_q;
            sck_d1_q  <= sck_s2_q;
            mosi_s1_q <= lmosi;
            mosi_s2_q <= mosi_s1_q;
            nss_s1_q  <= lnss;
            nss_s2_q  <= nss_s1_q;
            nss_d1_q  <= nss_s2_q;
            rise_q    <= sck_s2_q & ~sck_d1_q;
        end
    end

    assign nss_rise = nss_s2_q & ~nss_d1_q;
    assign dec      = (bit_cnt_q == FRAME_FULL);

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        abort     = 1'b0;
        if (dec) begin
            bit_cnt_d = '0;
        end else if (nss_rise && (bit_cnt_q != '0)) begin
            bit_cnt_d = '0;
            abort     = 1'b1;
        end else if (rise_q && !nss_s2_q) begin
            shift_d   = {shift_q[14:0], mosi_s2_q};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    assign cmd    = cmd_e'(shift_q[15:14]);
    assign idx_ok = ({1'b0, shift_q[7:0]} < 9'(SZPFIRED));
    assign grp_ok = (shift_q[13:8] < 6'(SZPFIRED / 8));

    always_comb begin
        fire_vec = '0;
        add_cnt  = '0;
        dec_err  = 1'b0;
        if (dec) begin
            case (cmd)
                CMD_FIRE: begin
                    if (idx_ok) begin
                        for (int i = 0; i < SZPFIRED; i++) begin
                            fire_vec[i] = (shift_q[7:0] == 8'(i));
                        end
                        add_cnt = 8'd1;
                    end else begin
                        dec_err = 1'b1;
                    end
                end
                CMD_MASK: begin
                    if (grp_ok) begin
                        for (int i = 0; i < SZPFIRED; i++) begin
                            fire_vec[i] = (shift_q[13:8] == 6'(i / 8)) && shift_q[i % 8];
                        end
                        for (int k = 0; k < 8; k++) begin
                            add_cnt = add_cnt + {7'b0, shift_q[k]};
                        end
                    end else begin
                        dec_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A fresh error in the clearing cycle keeps err set
    always_comb begin
        fired_cnt_d = fired_cnt_q + add_cnt;
        err_d       = err_q;
        if (dec_err || abort) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            fired_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            fired_cnt_q <= fired_cnt_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SZPFIRED; i++) begin
            if (reset) begin
                cnt_q[i] <= '0;
            end else if (fire_vec[i]) begin
                cnt_q[i] <= PW;
            end else if (cnt_q[i] != '0) begin
                cnt_q[i] <= cnt_q[i] - 8'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SZPFIRED; i++) begin
            FOut[i] = (cnt_q[i] != '0);
        end
    end

`ifdef SDRV_STATUS_EN
    logic        nss_fall, sck_fall;
    logic [15:0] status_q;
    logic        snap_err_q;

    assign nss_fall = ~nss_s2_q & nss_d1_q;
    assign sck_fall = ~sck_s2_q & sck_d1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q   <= '0;
            snap_err_q <= 1'b0;
        end else if (nss_fall) begin
            status_q   <= {err_q, 7'b0, fired_cnt_q};
            snap_err_q <= err_q;
        end else if (sck_fall && !nss_s2_q) begin
            status_q   <= {status_q[14:0], 1'b0};
        end
    end

    assign err_clr = dec & snap_err_q;
    assign lmiso   = ~nss_s2_q & status_q[15];
`else
    assign err_clr = 1'b0;
    assign lmiso   = 1'b0;
`endif

endmodule

// File: tb/tb_spike_driver_spi_mc.sv
// Directed bench for spike_driver_spi_mc; a second instance with a long pulse covers retrigger and mid-pulse reset.
module tb_spike_driver_spi_mc;

    logic        clk = 1'b0;
    logic        reset, lsck, lmosi, lnss;
    logic        lmiso, lmiso2;
    logic [31:0] FOut, FOut2;

    int checks  = 0;
    int errors  = 0;
    int nz_cnt  = 0;
    int gl_cnt  = 0;
    logic mon_zero = 1'b0;
    logic mon_hi   = 1'b0;

`ifdef SDRV_STATUS_EN
    localparam logic [15:0] EXP_STAT1 = 16'h8004;
    localparam logic [15:0] EXP_STAT2 = 16'h0004;
    localparam logic        EXP_ERR_AFTER = 1'b0;
`else
    localparam logic [15:0] EXP_STAT1 = 16'h0000;
    localparam logic [15:0] EXP_STAT2 = 16'h0000;
    localparam logic        EXP_ERR_AFTER = 1'b1;
`endif

    always #5 clk = ~clk;

    spike_driver_spi_mc #(.SZPFIRED(32), .PULSEW(4), .FRAMEW(16)) dut (
        .clk(clk), .reset(reset), .lsck(lsck), .lmosi(lmosi), .lnss(lnss),
        .lmiso(lmiso), .FOut(FOut)
    );

    spike_driver_spi_mc #(.SZPFIRED(32), .PULSEW(200), .FRAMEW(16)) dut2 (
        .clk(clk), .reset(reset), .lsck(lsck), .lmosi(lmosi), .lnss(lnss),
        .lmiso(lmiso2), .FOut(FOut2)
    );

    always @(negedge clk) begin
        if (mon_zero && (FOut !== 32'h0)) nz_cnt++;
        if (mon_hi && (FOut2[5] !== 1'b1)) gl_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic spi_start();
        @(negedge clk);
        lnss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        @(negedge clk);
        lmosi = b;
        repeat (3) @(negedge clk);
        m = lmiso;
        lsck = 1'b1;
        repeat (4) @(negedge clk);
        lsck = 1'b0;
    endtask

    task automatic spi_stop();
        repeat (4) @(negedge clk);
        lnss = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic send(input logic [15:0] f, output logic [15:0] m);
        logic b;
        spi_start();
        for (int i = 15; i >= 0; i--) begin
            spi_bit(f[i], b);
            m[i] = b;
        end
        spi_stop();
    endtask

    // Leaves the 16th lsck high, driven on a negedge, so the caller can time decode
    task automatic frame_hold(input logic [15:0] f);
        logic b;
        spi_start();
        for (int i = 15; i >= 1; i--) spi_bit(f[i], b);
        @(negedge clk);
        lmosi = f[0];
        repeat (3) @(negedge clk);
        lsck = 1'b1;
    endtask

    task automatic frame_release();
        @(negedge clk);
        lsck = 1'b0;
        spi_stop();
    endtask

    task automatic timed_fire(input logic [15:0] f, input logic [31:0] exp, input string tag);
        int w;
        frame_hold(f);
        repeat (4) @(posedge clk);
        #1 chk({tag, "_pre"}, FOut, 32'h0);
        @(posedge clk);
        #1 chk({tag, "_rise"}, FOut, exp);
        w = 1;
        for (int i = 0; i < 300 && (FOut === exp); i++) begin
            @(posedge clk);
            #1;
            if (FOut === exp) w++;
        end
        chk({tag, "_width"}, 32'(w), 32'd4);
        chk({tag, "_after"}, FOut, 32'h0);
        frame_release();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        logic        b;
        int          w;

        reset = 1'b1;
        lsck  = 1'b0;
        lmosi = 1'b0;
        lnss  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fout", FOut, 32'h0);
        chk("rst_miso", {31'b0, lmiso}, 32'h0);
        chk("rst_fc", {24'b0, dut.fired_cnt_q}, 32'h0);
        chk("rst_err", {31'b0, dut.err_q}, 32'h0);
        chk("rst_bitcnt", {27'b0, dut.bit_cnt_q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single fire
        timed_fire(16'h4005, 32'h0000_0020, "t1");
        chk("t1_fc", {24'b0, dut.fired_cnt_q}, 32'd1);

        // 2: retrigger on the long-pulse instance
        reset_dut();
        timed_fire(16'h4005, 32'h0000_0020, "t2a");
        mon_hi = 1'b1;
        frame_hold(16'h4005);
        repeat (4) @(posedge clk);
        #1 chk("t2_hold", {31'b0, FOut2[5]}, 32'd1);
        @(posedge clk);
        #1 chk("t2_reload", {24'b0, dut2.cnt_q[5]}, 32'd200);
        mon_hi = 1'b0;
        chk("t2_glitch", 32'(gl_cnt), 32'd0);
        w = 1;
        for (int i = 0; i < 400 && FOut2[5]; i++) begin
            @(posedge clk);
            #1;
            if (FOut2[5]) w++;
        end
        chk("t2_width", 32'(w), 32'd200);
        frame_release();
        chk("t2_fc", {24'b0, dut.fired_cnt_q}, 32'd2);

        // 3: masked group fire
        timed_fire(16'h8381, 32'h8100_0000, "t3");
        chk("t3_fc", {24'b0, dut.fired_cnt_q}, 32'd4);

        // 4: out-of-range commands, then status frames
        mon_zero = 1'b1;
        send(16'h4028, m);
        chk("t4_err_idx", {31'b0, dut.err_q}, 32'd1);
        send(16'h8405, m);
        chk("t4_err_grp", {31'b0, dut.err_q}, 32'd1);
        chk("t4_fc", {24'b0, dut.fired_cnt_q}, 32'd4);
        mon_zero = 1'b0;
        chk("t4_quiet", 32'(nz_cnt), 32'd0);
        send(16'hC000, m);
        chk("t4_stat1", {16'b0, m}, {16'b0, EXP_STAT1});
        chk("t4_err_after", {31'b0, dut.err_q}, {31'b0, EXP_ERR_AFTER});
        send(16'hC000, m);
        chk("t4_stat2", {16'b0, m}, {16'b0, EXP_STAT2});

        // 5: abort after 9 bits, then a clean frame
        reset_dut();
        mon_zero = 1'b1;
        spi_start();
        for (int i = 15; i >= 7; i--) spi_bit(1'b0 ^ (i == 14), b);
        spi_stop();
        chk("t5_err", {31'b0, dut.err_q}, 32'd1);
        chk("t5_bitcnt", {27'b0, dut.bit_cnt_q}, 32'd0);
        mon_zero = 1'b0;
        chk("t5_quiet", 32'(nz_cnt), 32'd0);
        timed_fire(16'h4000, 32'h0000_0001, "t5");
        chk("t5_fc", {24'b0, dut.fired_cnt_q}, 32'd1);

        // 6: reset during bit 10 while line 3 is active on the long-pulse instance
        send(16'h4003, m);
        spi_start();
        m = 16'h4007;
        for (int i = 15; i >= 7; i--) spi_bit(m[i], b);
        @(negedge clk);
        lmosi = m[6];
        chk("t6_active", {31'b0, FOut2[3]}, 32'd1);
        chk("t6_bitcnt9", {27'b0, dut2.bit_cnt_q}, 32'd9);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_fout2_rst", FOut2, 32'h0);
        chk("t6_fout_rst", FOut, 32'h0);
        chk("t6_bitcnt_rst", {27'b0, dut.bit_cnt_q}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        lnss  = 1'b1;
        repeat (6) @(negedge clk);
        timed_fire(16'h4007, 32'h0000_0080, "t6");
        chk("t6_fc", {24'b0, dut.fired_cnt_q}, 32'd1);
        chk("t6_err", {31'b0, dut.err_q}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_driver_spi_mc.md
Name: spike_driver_spi_mc

Overview:
- SPI-slave spike driver for a parametrised number of parallel firing lines.
- Host sends 16-bit command frames to fire single lines or masked groups of 8 lines.
- Each fired line is held high for a programmable pulse width; retriggers are supported.
- Sits between the host SPI link and the neuron array's parallel Firing Out bus. Next generation of the fixed 32-line SpikeDriver_SPI.

Parameters:
- SZPFIRED, 32: number of firing output lines (8..256, multiple of 8).
- PULSEW, 4: FOut pulse length in clk cycles (1..255).
- FRAMEW, 16: SPI frame length in bits (fixed encoding below; only 16 is supported).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- lsck  input  1  SPI clock, asynchronous to clk, mode 0, frequency ≤ clk/8.
- lmosi  input  1  SPI data in, MSB first.
- lnss  input  1  SPI select, active low.
- lmiso  output  1  SPI data out, MSB first.
- FOut  output  SZPFIRED  parallel firing outputs.

Behaviour:
- **Interface decision (already decided):** one clock, clk; reset is synchronous and active-high.
- **Reset:**
  - FOut=0, lmiso=0.
  - All pulse counters=0, bit counter=0, shift register=0, fired_count=0, err=0.
- **Reset mid-frame:** the partial frame is discarded and FOut clears on the same edge. Reset has priority over every other event.
- **Synchronisers:** lsck, lmosi and lnss each pass through a 2-flop synchroniser. Edge detect runs on the synced lsck; there is no other logic on the raw pins.
- **Receive:**
  - On each synced lsck rising edge while synced lnss=0, shift lmosi into the LSB and increment the bit counter.
  - When the counter reaches 16, decode the frame on the next clk and clear the counter.
  - Frames longer than 16 bits are decoded as back-to-back 16-bit frames.
- **Frame format [15:14] cmd, [13:0] payload:**
  - 00 NOP: no action.
  - 01 FIRE: index = payload[7:0].
    - If index < SZPFIRED, fire line index and increment fired_count by 1.
    - Otherwise the command is ignored and err is set.
  - 10 FIRE_MASK: group g = payload[13:8], mask = payload[7:0].
    - If g < SZPFIRED/8, fire lines g*8+k for every mask bit k=1, and add popcount(mask) to fired_count.
    - Otherwise set err.
  - 11 STATUS: no action; exists only to clock status out.
- **Firing:**
  - Each line has an 8-bit down-counter; FOut[i] = (counter_i != 0).
  - Firing a line loads PULSEW on the decode edge, so FOut[i] rises on that edge.
  - Latency: FOut rises on the 4th clk edge after the edge that first samples the 16th lsck high.
  - Retrigger while active reloads PULSEW, extending the pulse with no glitch low.
  - If a reload and a count reaching 0 happen in the same cycle, the reload wins.
- **Arithmetic:** fired_count is 8 bits and wraps 255→0. Counters never underflow; they hold at 0.
- **Frame abort:** synced lnss rising with bit counter ≠ 0 discards the partial frame, sets err and clears the counter. Pulses already active continue.
- **Simultaneous events:** a decode and an abort in the same cycle cannot occur, because decode clears the counter.

Optional Feature:
- Macro SDRV_STATUS_EN.
- **Defined:**
  - On synced lnss falling, snapshot status = {err, 7'b0, fired_count}.
  - lmiso presents status[15] immediately and shifts the next bit on each synced lsck falling edge. lmiso=0 when lnss=1.
  - err clears on decode of a full frame whose snapshot had err=1. A new error raised in that same cycle takes priority and err stays set.
- **Undefined:** lmiso is tied to 0, and no snapshot or shift-out logic is built. err and fired_count remain internal.

Test Plan:
1. Reset, then send 0x4005 (FIRE 5) → FOut=0x00000020 for exactly 4 clk cycles (PULSEW=4), fired_count=1.
2. Send FIRE 5, then FIRE 5 again while line 5 is still active → FOut[5] stays high continuously, ending PULSEW cycles after the second decode; fired_count=2.
3. Send 0x8381 (FIRE_MASK g=3, mask 0x81) → FOut bits 24 and 31 high together for 4 cycles; fired_count increments by 2.
4. Send 0x4028 (index 40 ≥ 32), then 0x8405 (g=4 out of range) → FOut stays 0, err=1. With SDRV_STATUS_EN, the next 0xC000 frame shifts out 0x80xx; the following frame shifts out err=0.
5. Raise lnss after 9 bits of a FIRE frame → no FOut activity, err=1. The next full FIRE 0 frame then fires line 0 normally.
6. Assert reset during bit 10 and while FOut[3] is active → FOut=0 on the reset edge. A subsequent full frame decodes correctly from bit 0.
